// File: rtl/sm_uart_pkg.sv
// Shared definitions for the colour-report UART receiver: bit timing defaults,
// ASCII frame characters, colour codes, FSM encodings and character-class helpers.
package sm_uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int HALF_BIT_DEF     = 217;

  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_I    = 8'h49;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_NL   = 8'h0A;
  localparam logic [7:0] CH_1    = 8'h31;
  localparam logic [7:0] CH_2    = 8'h32;
  localparam logic [7:0] CH_3    = 8'h33;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_N    = 8'h4E;
  localparam logic [7:0] CH_W    = 8'h57;

  // {red,green,blue}, matching the transmitter's led[2:0] ordering
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_NONE  = 3'b000;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_e;

  typedef enum logic [3:0] {
    P_IDLE, P_I1, P_DASH1, P_S2, P_I2, P_M, P_DASH2,
    P_DIG, P_DASH3, P_LET, P_DASH4, P_HASH, P_NL
  } msg_state_e;

  function automatic logic [2:0] digit_color(input logic [7:0] b);
    case (b)
      CH_1:    return COL_RED;
      CH_2:    return COL_GREEN;
      CH_3:    return COL_BLUE;
      default: return COL_NONE;
    endcase
  endfunction

  function automatic logic [2:0] letter_color(input logic [7:0] b);
    case (b)
      CH_P:    return COL_RED;
      CH_N:    return COL_GREEN;
      CH_W:    return COL_BLUE;
      default: return COL_NONE;
    endcase
  endfunction

  function automatic logic [7:0] expected_char(input msg_state_e st);
    case (st)
      P_IDLE, P_S2:                    return CH_S;
      P_I1, P_I2:                      return CH_I;
      P_M:                             return CH_M;
      P_DASH1, P_DASH2, P_DASH3, P_DASH4: return CH_DASH;
      P_HASH:                          return CH_HASH;
      P_NL:                            return CH_NL;
      default:                         return 8'h00;
    endcase
  endfunction

  // Digit and letter positions accept a class of characters rather than one literal
  function automatic logic char_matches(input msg_state_e st, input logic [7:0] b);
    case (st)
      P_DIG:   return digit_color(b) != COL_NONE;
      P_LET:   return letter_color(b) != COL_NONE;
      default: return b == expected_char(st);
    endcase
  endfunction

endpackage

// File: rtl/sm_uart_rx_byte.sv
// Byte receiver: two-flop rx synchronizer plus 8N1 start/data/stop FSM.
// Emits each good byte with a one-cycle strobe, or frame_err when the stop bit is low.
module sm_uart_rx_byte
  import sm_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = HALF_BIT_DEF
) (
  input  logic       clk_50_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_byte_valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q, rx_s_q;
  byte_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             half_tick, bit_tick;

  assign half_tick = (cnt_q == HALF_LAST);
  assign bit_tick  = (cnt_q == BIT_LAST);

  always_ff @(posedge clk_50_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= B_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // STOP returns to IDLE at mid-bit so a start edge right after the stop bit is caught
  always_comb begin
    state_d = state_q;
    case (state_q)
      B_IDLE:  if (!rx_s_q) state_d = B_START;
      B_START: if (half_tick) state_d = rx_s_q ? B_IDLE : B_DATA;
      B_DATA:  if (bit_tick && bit_idx_q == 3'd7) state_d = B_STOP;
      B_STOP:  if (bit_tick) state_d = B_IDLE;
      default: state_d = B_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    if (state_q == B_IDLE || state_d != state_q || (state_q == B_DATA && bit_tick)) begin
      cnt_d = '0;
    end
    case (state_q)
      B_START: if (half_tick) bit_idx_d = '0;
      B_DATA: begin
        if (bit_tick) begin
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
        end
      end
      B_STOP: begin
        if (bit_tick) begin
          if (rx_s_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign rx_byte_o       = byte_q;
  assign rx_byte_valid_o = valid_q;
  assign frame_err_o     = ferr_q;

endmodule

// File: rtl/sm_msg_uart_rx.sv
// Colour-report receiver: recovers bytes from the serial line and parses
// "SI-SIM-<d>-<c>-#\n", reporting a consistent digit/letter pair as a one-hot colour.
module sm_msg_uart_rx
  import sm_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = HALF_BIT_DEF
) (
  input  logic       clk_50_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_byte_valid_o,
  output logic       frame_err_o,
  output logic       msg_valid_o,
  output logic [2:0] msg_color_o,
  output logic       msg_err_o
);

  msg_state_e pstate_q, pstate_d;
  logic [2:0] digit_q, digit_d;
  logic [2:0] letter_q, letter_d;
  logic [2:0] color_q, color_d;
  logic       mvalid_q, mvalid_d;
  logic       merr_q, merr_d;
  logic       char_ok;

  sm_uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .HALF_BIT    (HALF_BIT)
  ) u_rx_byte (
    .clk_50_i       (clk_50_i),
    .rst_n_i        (rst_n_i),
    .rx_i           (rx_i),
    .rx_byte_o      (rx_byte_o),
    .rx_byte_valid_o(rx_byte_valid_o),
    .frame_err_o    (frame_err_o)
  );

  assign char_ok = char_matches(pstate_q, rx_byte_o);

  always_ff @(posedge clk_50_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pstate_q <= P_IDLE;
      digit_q  <= '0;
      letter_q <= '0;
      color_q  <= '0;
      mvalid_q <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      digit_q  <= digit_d;
      letter_q <= letter_d;
      color_q  <= color_d;
      mvalid_q <= mvalid_d;
      merr_q   <= merr_d;
    end
  end

  // A stray 'S' can itself begin a new frame, so resync to the position after it
  always_comb begin
    pstate_d = pstate_q;
    if (frame_err_o) begin
      pstate_d = P_IDLE;
    end else if (rx_byte_valid_o) begin
      if (char_ok) begin
        pstate_d = (pstate_q == P_NL) ? P_IDLE : msg_state_e'(pstate_q + 4'd1);
      end else begin
        pstate_d = (rx_byte_o == CH_S) ? P_I1 : P_IDLE;
      end
    end
  end

  always_comb begin
    digit_d  = digit_q;
    letter_d = letter_q;
    color_d  = color_q;
    mvalid_d = 1'b0;
    merr_d   = 1'b0;
    if (rx_byte_valid_o && char_ok) begin
      case (pstate_q)
        P_DIG: digit_d  = digit_color(rx_byte_o);
        P_LET: letter_d = letter_color(rx_byte_o);
        P_NL: begin
          if (digit_q == letter_q) begin
            color_d  = digit_q;
            mvalid_d = 1'b1;
          end else begin
            merr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign msg_valid_o = mvalid_q;
  assign msg_color_o = color_q;
  assign msg_err_o   = merr_q;

endmodule

// File: tb/tb_sm_msg_uart_rx.sv
// Directed and randomized frames for sm_msg_uart_rx, checked against a
// position-counting frame model built from the message format rules.
module tb_sm_msg_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int EV_ERR = 8;

  logic       clk_50_i = 1'b0;
  logic       rst_n_i  = 1'b0;
  logic       rx_i     = 1'b1;
  logic [7:0] rx_byte_o;
  logic       rx_byte_valid_o;
  logic       frame_err_o;
  logic       msg_valid_o;
  logic [2:0] msg_color_o;
  logic       msg_err_o;

  always #10 clk_50_i = ~clk_50_i;

  sm_msg_uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk_50_i       (clk_50_i),
    .rst_n_i        (rst_n_i),
    .rx_i           (rx_i),
    .rx_byte_o      (rx_byte_o),
    .rx_byte_valid_o(rx_byte_valid_o),
    .frame_err_o    (frame_err_o),
    .msg_valid_o    (msg_valid_o),
    .msg_color_o    (msg_color_o),
    .msg_err_o      (msg_err_o)
  );

  int checks   = 0;
  int failures = 0;

  // Observed events (appended only by the monitor)
  logic [7:0] got_bytes[$];
  int         got_ev[$];
  int         got_ferr = 0;

  // Expected events and model state (written only by the stimulus block)
  logic [7:0] exp_bytes[$];
  int         exp_ev[$];
  int         exp_ferr = 0;
  int         cur_b = 0;
  int         cur_e = 0;
  string      pat = "SI-SIM-d-c-#\n";
  int         m_pos = 0;
  logic [2:0] m_dig = 3'b000;
  logic [2:0] m_let = 3'b000;
  logic [2:0] m_color = 3'b000;
  logic [7:0] m_last = 8'h00;

  always @(negedge clk_50_i) begin
    if (rst_n_i) begin
      if (rx_byte_valid_o) got_bytes.push_back(rx_byte_o);
      if (frame_err_o) got_ferr++;
      if (msg_valid_o) got_ev.push_back(int'(msg_color_o));
      if (msg_err_o) got_ev.push_back(EV_ERR);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [2:0] ref_digit(input logic [7:0] b);
    if (b >= "1" && b <= "3") return 3'b100 >> (b - "1");
    return 3'b000;
  endfunction

  function automatic logic [2:0] ref_letter(input logic [7:0] b);
    case (b)
      "P":     return 3'b100;
      "N":     return 3'b010;
      "W":     return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic ok;
    exp_bytes.push_back(b);
    m_last = b;
    case (m_pos)
      7:       ok = (ref_digit(b) != 3'b000);
      9:       ok = (ref_letter(b) != 3'b000);
      default: ok = (b == pat[m_pos]);
    endcase
    if (!ok) begin
      m_pos = (b == "S") ? 1 : 0;
    end else begin
      if (m_pos == 7) m_dig = ref_digit(b);
      if (m_pos == 9) m_let = ref_letter(b);
      if (m_pos == 12) begin
        if (m_dig == m_let) begin
          m_color = m_dig;
          exp_ev.push_back(int'(m_dig));
        end else begin
          exp_ev.push_back(EV_ERR);
        end
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  // Called on a falling clock edge; returns on a falling clock edge
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_50_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk_50_i);
    end
    rx_i = stop_bit;
    repeat (CPB) @(negedge clk_50_i);
    rx_i = 1'b1;
    repeat (gap) @(negedge clk_50_i);
    if (stop_bit) begin
      model_byte(b);
    end else begin
      exp_ferr++;
      m_pos = 0;
    end
  endtask

  task automatic send_string(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, gap);
  endtask

  task automatic check_step(input string tag);
    repeat (4) @(negedge clk_50_i);
    chk({tag, "/nbytes"}, got_bytes.size(), exp_bytes.size());
    for (int i = cur_b; i < got_bytes.size() && i < exp_bytes.size(); i++)
      chk({tag, "/byte"}, got_bytes[i], exp_bytes[i]);
    cur_b = exp_bytes.size();
    chk({tag, "/nmsg"}, got_ev.size(), exp_ev.size());
    for (int i = cur_e; i < got_ev.size() && i < exp_ev.size(); i++)
      chk({tag, "/msg"}, got_ev[i], exp_ev[i]);
    cur_e = exp_ev.size();
    chk({tag, "/frame_err"}, got_ferr, exp_ferr);
    chk({tag, "/msg_color"}, msg_color_o, m_color);
    chk({tag, "/rx_byte"}, rx_byte_o, m_last);
    $display("step %s: bytes=%0d msgs=%0d frame_errs=%0d color=%b", tag,
             got_bytes.size(), got_ev.size(), got_ferr, msg_color_o);
  endtask

  initial begin
    logic [7:0] fr[$];
    string noise  = "SI-MX#";
    string digits = "1234";
    string lets   = "PNWX";
    int    n;
    int    gap;

    repeat (3) @(negedge clk_50_i);
    chk("reset/outputs", {rx_byte_o, rx_byte_valid_o, frame_err_o, msg_valid_o, msg_color_o, msg_err_o}, 0);
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk_50_i);

    send_string("SI-SIM-1-P-#\n", CPB);
    check_step("t1_red");
    send_string("SI-SIM-3-W-#\n", 0);
    check_step("t2_b2b_blue");
    send_string("SI-SIM-2-P-#\n", 0);
    check_step("t3_mismatch");

    send_byte(8'h53, 1'b0, 2 * CPB);
    check_step("t4_frame_err");
    send_string("SI-SIM-2-N-#\n", 2);
    check_step("t4_green");

    rx_i = 1'b0;
    repeat (HALF - 2) @(negedge clk_50_i);
    rx_i = 1'b1;
    repeat (3 * CPB) @(negedge clk_50_i);
    check_step("t5_glitch");
    send_byte(8'h41, 1'b1, CPB);
    check_step("t5_after_glitch");

    send_string("SI-SSI-SIM-1-P-#\n", 0);
    check_step("t6_resync");

    send_string("SI-S", 0);
    rx_i = 1'b0;
    repeat (3 * CPB) @(negedge clk_50_i);
    #2 rst_n_i = 1'b0;
    #1 chk("rst_mid/outputs", {rx_byte_o, rx_byte_valid_o, frame_err_o, msg_valid_o, msg_color_o, msg_err_o}, 0);
    rx_i = 1'b1;
    repeat (5) @(negedge clk_50_i);
    rst_n_i = 1'b1;
    m_pos   = 0;
    m_color = 3'b000;
    m_last  = 8'h00;
    repeat (2 * CPB) @(negedge clk_50_i);
    send_string("SI-SIM-3-W-#\n", 0);
    check_step("rst_then_blue");

    for (int f = 0; f < 8; f++) begin
      fr.delete();
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) fr.push_back(noise[$urandom_range(0, 5)]);
      for (int i = 0; i < 13; i++) begin
        if (i == 7)      fr.push_back(digits[$urandom_range(0, 3)]);
        else if (i == 9) fr.push_back(lets[$urandom_range(0, 3)]);
        else             fr.push_back(pat[i]);
      end
      if ($urandom_range(0, 5) == 0) fr[$urandom_range(0, fr.size() - 1)] = "Z";
      foreach (fr[i]) begin
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
        send_byte(fr[i], 1'b1, gap);
      end
      check_step($sformatf("rand%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
